// File: rtl/ex1_trial_ctrl.sv
// Trial sequencer for the 2-bit ex1 FSM: preloads state, holds a pseudo-random A, counts TARGET hits.
// Latency: campaign of NUM_TRIALS*(1+TRIAL_LEN) cycles from start edge to done; results registered.
// Backpressure: none; start is honoured only in IDLE/DONE and ignored while busy.
module ex1_trial_ctrl #(
  parameter int unsigned TRIAL_LEN   = 100,
  parameter int unsigned NUM_TRIALS  = 10000,
  parameter logic [1:0]  TARGET      = 2'b11,
  parameter logic [1:0]  START_STATE = 2'b00,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [1:0]  dut_state,
  output logic        dut_load,
  output logic [1:0]  dut_load_state,
  output logic        dut_a,
  output logic        busy,
  output logic        done,
  output logic [15:0] hit_count,
  output logic [15:0] min_latency,
  output logic [15:0] trial_count
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [15:0] LAST_CYC   = 16'(TRIAL_LEN - 1);
  localparam logic [15:0] LAST_TRIAL = 16'(NUM_TRIALS - 1);

  state_t      state, state_nxt;
  logic [15:0] cyc;
  logic [15:0] lfsr;
  logic        hit_flag;
  logic        hit_now;
  logic        last_cyc;
  logic        last_trial;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // First TARGET sighting of the trial, end-of-trial and end-of-campaign decodes
  always_comb begin
    hit_now    = (state == RUN) && (dut_state == TARGET) && !hit_flag;
    last_cyc   = (state == RUN) && (cyc == LAST_CYC);
    last_trial = (trial_count == LAST_TRIAL);
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt      = state;
    dut_load       = 1'b0;
    dut_load_state = START_STATE;
    busy           = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        dut_load  = 1'b1;
        busy      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_cyc) state_nxt = last_trial ? DONE : LOAD;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Trial datapath: LFSR/A draw on entry to LOAD, cycle counter, hit and latency tracking
  always_ff @(posedge CLK) begin
    if (RST) begin
      dut_a       <= 1'b0;
      hit_count   <= 16'h0000;
      min_latency <= 16'hFFFF;
      trial_count <= 16'h0000;
      lfsr        <= LFSR_SEED;
      cyc         <= 16'h0000;
      hit_flag    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Campaign restarts from the seed; the first A is seed bit0
            hit_count   <= 16'h0000;
            trial_count <= 16'h0000;
            min_latency <= 16'hFFFF;
            dut_a       <= LFSR_SEED[0];
            lfsr        <= lfsr_step(LFSR_SEED);
            cyc         <= 16'h0000;
            hit_flag    <= 1'b0;
          end
        end
        LOAD: begin
          cyc      <= 16'h0000;
          hit_flag <= 1'b0;
        end
        RUN: begin
          cyc <= cyc + 16'd1;
          if (hit_now) begin
            hit_flag <= 1'b1;
            if (cyc < min_latency) min_latency <= cyc;
          end
          if (last_cyc) begin
            // A hit on the final cycle still counts for this trial
            if ((hit_flag || hit_now) && (hit_count != 16'hFFFF))
              hit_count <= hit_count + 16'd1;
            trial_count <= trial_count + 16'd1;
            if (!last_trial) begin
              dut_a <= lfsr[0];
              lfsr  <= lfsr_step(lfsr);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex1_trial_ctrl.sv
// Directed bench for ex1_trial_ctrl: three instances cover the main, TARGET==START_STATE and TRIAL_LEN=1 configs.
// Inputs are driven and outputs sampled at the falling edge.
// Summary line reports comparison and failure counts.
module tb_ex1_trial_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST, start, start_z, start_one;
  logic [1:0] ds, ds_zero;

  logic        a_load, a_a, a_busy, a_done;
  logic [1:0]  a_lst;
  logic [15:0] a_hits, a_min, a_trials;
  logic        z_load, z_a, z_busy, z_done;
  logic [1:0]  z_lst;
  logic [15:0] z_hits, z_min, z_trials;
  logic        o_load, o_a, o_busy, o_done;
  logic [1:0]  o_lst;
  logic [15:0] o_hits, o_min, o_trials;

  int checks = 0;
  int errors = 0;

  ex1_trial_ctrl #(.TRIAL_LEN(4), .NUM_TRIALS(2), .TARGET(2'b11), .START_STATE(2'b00), .LFSR_SEED(16'hACE1)) u_dut (
    .CLK(CLK), .RST(RST), .start(start), .dut_state(ds),
    .dut_load(a_load), .dut_load_state(a_lst), .dut_a(a_a), .busy(a_busy), .done(a_done),
    .hit_count(a_hits), .min_latency(a_min), .trial_count(a_trials));

  ex1_trial_ctrl #(.TRIAL_LEN(4), .NUM_TRIALS(2), .TARGET(2'b00), .START_STATE(2'b00), .LFSR_SEED(16'hACE1)) u_z (
    .CLK(CLK), .RST(RST), .start(start_z), .dut_state(ds_zero),
    .dut_load(z_load), .dut_load_state(z_lst), .dut_a(z_a), .busy(z_busy), .done(z_done),
    .hit_count(z_hits), .min_latency(z_min), .trial_count(z_trials));

  ex1_trial_ctrl #(.TRIAL_LEN(1), .NUM_TRIALS(20), .TARGET(2'b11), .START_STATE(2'b00), .LFSR_SEED(16'hACE1)) u_one (
    .CLK(CLK), .RST(RST), .start(start_one), .dut_state(ds_zero),
    .dut_load(o_load), .dut_load_state(o_lst), .dut_a(o_a), .busy(o_busy), .done(o_done),
    .hit_count(o_hits), .min_latency(o_min), .trial_count(o_trials));

  function automatic logic [15:0] lfsr_ref(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, " load"}, a_load, 1'b0);
    chk ({tag, " lst"}, 16'(a_lst), 16'h0000);
    chk1({tag, " a"}, a_a, 1'b0);
    chk1({tag, " busy"}, a_busy, 1'b0);
    chk1({tag, " done"}, a_done, 1'b0);
    chk ({tag, " hits"}, a_hits, 16'h0000);
    chk ({tag, " min"}, a_min, 16'hFFFF);
    chk ({tag, " trials"}, a_trials, 16'h0000);
  endtask

  // Two-trial campaign on u_dut; pattern nibble pairs give dut_state for RUN cyc 0..3
  task automatic campaign(input string tag, input logic [7:0] p0, input logic [7:0] p1,
                          input bit poke, input logic [15:0] exp_hits, input logic [15:0] exp_min);
    logic [7:0] pat;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 2; t++) begin
      pat = (t == 0) ? p0 : p1;
      chk1({tag, " load strobe"}, a_load, 1'b1);
      chk1({tag, " load busy"}, a_busy, 1'b1);
      chk1({tag, " load done"}, a_done, 1'b0);
      chk1({tag, " load a"}, a_a, (t == 0) ? 1'b1 : 1'b0);
      chk ({tag, " load trials"}, a_trials, 16'(t));
      ds = 2'b00;
      for (int c = 0; c < 4; c++) begin
        step();
        ds    = pat[2*c +: 2];
        start = (poke && t == 0 && c == 1);
        chk1({tag, " run load"}, a_load, 1'b0);
        chk1({tag, " run busy"}, a_busy, 1'b1);
        chk1({tag, " run done"}, a_done, 1'b0);
        chk1({tag, " run a"}, a_a, (t == 0) ? 1'b1 : 1'b0);
      end
      step();
      ds    = 2'b00;
      start = 1'b0;
    end
    chk1({tag, " done"}, a_done, 1'b1);
    chk1({tag, " done busy"}, a_busy, 1'b0);
    chk1({tag, " done load"}, a_load, 1'b0);
    chk ({tag, " hits"}, a_hits, exp_hits);
    chk ({tag, " min"}, a_min, exp_min);
    chk ({tag, " trials"}, a_trials, 16'd2);
    step();
    chk1({tag, " done hold"}, a_done, 1'b1);
    chk ({tag, " hits hold"}, a_hits, exp_hits);
  endtask

  logic [15:0] model;

  initial begin
    RST = 1'b1; start = 1'b0; start_z = 1'b0; start_one = 1'b0;
    ds = 2'b00; ds_zero = 2'b00;
    step();
    step();
    chk_reset_vals("reset");
    RST = 1'b0;
    step();
    chk1("idle busy", a_busy, 1'b0);

    campaign("nohit",  8'h00, 8'h00, 1'b0, 16'd0, 16'hFFFF);
    campaign("single", 8'h30, 8'h00, 1'b0, 16'd1, 16'd2);
    campaign("extra",  8'hF0, 8'h00, 1'b1, 16'd1, 16'd2);
    campaign("minlat", 8'hC0, 8'h0C, 1'b0, 16'd2, 16'd1);
    campaign("repeat", 8'hC0, 8'h0C, 1'b0, 16'd2, 16'd1);

    // Reset in the middle of a RUN after a hit has already lowered min_latency
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    ds = 2'b11;
    step();
    ds = 2'b00;
    chk("midrun min", a_min, 16'd0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk_reset_vals("midrun rst");
    step();
    chk1("midrun idle", a_busy, 1'b0);

    // Reset and start together: reset wins
    RST = 1'b1; start = 1'b1;
    step();
    RST = 1'b0; start = 1'b0;
    chk1("rst+start busy", a_busy, 1'b0);
    chk1("rst+start load", a_load, 1'b0);
    step();
    chk1("rst+start idle", a_busy, 1'b0);

    // TARGET == START_STATE: every trial hits at cycle 0
    start_z = 1'b1;
    step();
    start_z = 1'b0;
    repeat (9) step();
    chk1("zero pre-done", z_done, 1'b0);
    step();
    chk1("zero done", z_done, 1'b1);
    chk ("zero hits", z_hits, 16'd2);
    chk ("zero min", z_min, 16'd0);
    chk ("zero trials", z_trials, 16'd2);

    // TRIAL_LEN=1: LOAD/RUN alternate every cycle; A follows the reference LFSR
    model = 16'hACE1;
    start_one = 1'b1;
    step();
    start_one = 1'b0;
    for (int t = 0; t < 20; t++) begin
      chk1("one load", o_load, 1'b1);
      chk1("one a", o_a, model[0]);
      model = lfsr_ref(model);
      step();
      chk1("one run load", o_load, 1'b0);
      chk1("one run busy", o_busy, 1'b1);
      step();
    end
    chk1("one done", o_done, 1'b1);
    chk ("one trials", o_trials, 16'd20);
    chk ("one hits", o_hits, 16'd0);
    chk ("one min", o_min, 16'hFFFF);
    chk ("lfsr first step", lfsr_ref(16'hACE1), 16'h5670);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
